w5300_bus_arbiter: RTL and testbench

- Shares the single W5300 register-access bus (caddr/wr_data/rd_data/op_status) among NUM_REQ internal requesters, e.g. common/socket init, UDP TX engine, RX engine and interrupt handler.
- Requester 0 optionally has fixed top priority; the rest are round-robin.
- A lock lets one requester keep the bus for multi-word sequences such as SEND_SIZE hi/lo or DST_IP hi/lo.
- A watchdog terminates accesses the W5300 driver never completes.

---
 rtl/w5300_bus_arbiter.sv | 108 ++++++++++
 tb/tb_w5300_bus_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w5300_bus_arbiter.sv
// w5300_bus_arbiter: shares the W5300 register bus among requesters with priority, round-robin, lock and watchdog
module w5300_bus_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int PRIO0          = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_rd,
    input  logic [NUM_REQ-1:0]    req_lock,
    input  logic [NUM_REQ*10-1:0] req_addr,
    input  logic [NUM_REQ*16-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [NUM_REQ-1:0]    req_grant,
    output logic [15:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  timeout_flag,
    output logic                  busy,
    output logic [11:0]           caddr,
    output logic [15:0]           wr_data,
    input  logic [15:0]           rd_data,
    input  logic                  op_status
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    typedef enum logic [1:0] {IDLE, ACCESS, GAP} state_t;
    state_t state, state_d;
    logic [PW-1:0] owner, ptr, win, cand;
    logic win_vld, win_prio, locked, done, tmo;
    logic [CW-1:0] wdog;
    logic [9:0] addr_a [NUM_REQ];
    logic [15:0] wdata_a [NUM_REQ];
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[g*10 +: 10];
        assign wdata_a[g] = req_wdata[g*16 +: 16];
    end
    assign done = state == ACCESS && op_status;
    assign tmo  = state == ACCESS && !op_status && TIMEOUT_CYCLES != 0 && wdog == CW'(TIMEOUT_CYCLES - 1);
    assign busy = state != IDLE;
    // winner selection: held lock, then requester-0 priority, then round-robin after the pointer
    always_comb begin
        win = ptr;
        win_vld = 1'b0;
        win_prio = 1'b0;
        cand = ptr;
        if (locked && req_valid[owner]) begin
            win = owner;
            win_vld = 1'b1;
        end else if (PRIO0 != 0 && req_valid[0]) begin
            win = '0;
            win_vld = 1'b1;
            win_prio = 1'b1;
        end else for (int i = NUM_REQ; i >= 1; i--) begin
            cand = PW'((int'(ptr) + i) % NUM_REQ);
            if (req_valid[cand]) begin
                win = cand;
                win_vld = 1'b1;
            end
        end
    end
    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_d;
    // next state: GAP always lasts exactly one cycle
    always_comb
        state_d = (state == IDLE) ? (win_vld ? ACCESS : IDLE) :
                  (state == ACCESS) ? ((done || tmo) ? GAP : ACCESS) : IDLE;
    // bus command, ownership, watchdog and response registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            owner <= '0;
            ptr <= '0;
            locked <= 1'b0;
            wdog <= '0;
            caddr <= 12'hC00;
            wr_data <= '0;
            req_ack <= '0;
            req_grant <= '0;
            rsp_rdata <= '0;
            rsp_err <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            req_ack <= '0;
            if (state == IDLE) begin
                locked <= 1'b0;
                req_grant <= win_vld ? NUM_REQ'(1) << win : '0;
                if (win_vld) begin
                    owner <= win;
                    caddr <= {1'b0, req_rd[win], addr_a[win]};
                    wr_data <= wdata_a[win];
                    wdog <= '0;
                    if (!win_prio) ptr <= win;
                end
            end else if (state == ACCESS) begin
                if (!(&wdog)) wdog <= wdog + CW'(1);
                if (done || tmo) begin
                    caddr[11] <= 1'b1;
                    req_ack <= req_grant;
                    rsp_rdata <= done ? rd_data : '0;
                    rsp_err <= !done;
                    locked <= done && req_lock[owner];
                    timeout_flag <= timeout_flag || !done;
                end
            end else if (!locked) req_grant <= '0;
        end
endmodule

// File: tb/tb_w5300_bus_arbiter.sv
// tb_w5300_bus_arbiter: scoreboard bench for the W5300 bus arbiter (dut 0: round-robin, dut 1: requester-0 priority)
module tb_w5300_bus_arbiter;
    localparam int N = 4;
    typedef struct {
        logic [11:0] caddr;
        logic [15:0] wdata;
        logic [3:0]  ack;
        logic [15:0] rdata;
        logic        err;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req_valid [2], req_rd [2], req_lock [2], req_ack [2], req_grant [2];
    logic [N*10-1:0] req_addr [2];
    logic [N*16-1:0] req_wdata [2];
    logic [15:0] rsp_rdata [2], wr_data [2], rd_data [2];
    logic rsp_err [2], timeout_flag [2], busy [2], op_status [2];
    logic [11:0] caddr [2], prev_c [2];
    int checks = 0, failures = 0;
    bit hold [2], drv_hang [2];
    int drv_lat [2], cnt [2];
    logic [15:0] drv_rdata [2];
    bit nxt_v;
    int nxt_r;
    logic [9:0] nxt_a;
    bit nxt_lk;
    exp_t q0 [$], q1 [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        w5300_bus_arbiter #(.NUM_REQ(N), .PRIO0(g), .TIMEOUT_CYCLES(16)) dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid(req_valid[g]), .req_rd(req_rd[g]), .req_lock(req_lock[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .req_ack(req_ack[g]), .req_grant(req_grant[g]),
            .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
            .timeout_flag(timeout_flag[g]), .busy(busy[g]),
            .caddr(caddr[g]), .wr_data(wr_data[g]),
            .rd_data(rd_data[g]), .op_status(op_status[g])
        );
    end

    task automatic chk(string name, int g, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h", name, g, act, exp);
        end
    endtask

    task automatic push(int g, logic [11:0] c, logic [15:0] w, logic [3:0] a, logic [15:0] d, logic e);
        exp_t x;
        x.caddr = c;
        x.wdata = w;
        x.ack = a;
        x.rdata = d;
        x.err = e;
        if (g == 0) q0.push_back(x);
        else q1.push_back(x);
    endtask

    task automatic set_req(int g, int r, logic rd, logic lk, logic [9:0] a, logic [15:0] d);
        req_rd[g][r] = rd;
        req_lock[g][r] = lk;
        req_addr[g][r*10 +: 10] = a;
        req_wdata[g][r*16 +: 16] = d;
        req_valid[g][r] = 1'b1;
    endtask

    task automatic drain(int g);
        int n = 0;
        while (((g == 0) ? q0.size() : q1.size()) != 0 || busy[g]) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                checks++;
                failures++;
                $display("FAIL drain dut%0d pending=%0d", g, (g == 0) ? q0.size() : q1.size());
                if (g == 0) q0.delete();
                else q1.delete();
                break;
            end
        end
        @(negedge clk);
    endtask

    // W5300 driver model: answers op_status after drv_lat strobe cycles, garbage rd_data otherwise
    always @(negedge clk)
        for (int g = 0; g < 2; g++) begin
            if (!rst_n || caddr[g][11]) begin
                cnt[g] = 0;
                op_status[g] = 1'b0;
            end else begin
                cnt[g]++;
                op_status[g] = !drv_hang[g] && cnt[g] == drv_lat[g];
            end
            rd_data[g] = op_status[g] ? drv_rdata[g] : 16'hDEAD;
        end

    // requester model: drop or replace a request once acked
    always @(negedge clk)
        for (int g = 0; g < 2; g++)
            for (int r = 0; r < N; r++)
                if (req_ack[g][r]) begin
                    if (g == 0 && nxt_v && nxt_r == r) begin
                        req_addr[0][r*10 +: 10] = nxt_a;
                        req_lock[0][r] = nxt_lk;
                        nxt_v = 1'b0;
                    end else if (!hold[g]) req_valid[g][r] = 1'b0;
                end

    // monitor: command checked at strobe start, response checked and popped at ack
    always @(negedge clk)
        for (int g = 0; g < 2; g++) begin
            exp_t e;
            if (rst_n) begin
                if (!caddr[g][11] && prev_c[g][11]) begin
                    if (((g == 0) ? q0.size() : q1.size()) == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL strobe dut%0d unexpected caddr=%0h", g, caddr[g]);
                    end else begin
                        if (g == 0) e = q0[0];
                        else e = q1[0];
                        chk("caddr", g, caddr[g], e.caddr);
                        chk("wr_data", g, wr_data[g], e.wdata);
                    end
                end
                if (req_ack[g] != 0) begin
                    if (((g == 0) ? q0.size() : q1.size()) == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL ack dut%0d unexpected ack=%0h", g, req_ack[g]);
                    end else begin
                        if (g == 0) e = q0.pop_front();
                        else e = q1.pop_front();
                        chk("ack", g, req_ack[g], e.ack);
                        chk("grant_at_ack", g, req_grant[g], e.ack);
                        chk("rsp_rdata", g, rsp_rdata[g], e.rdata);
                        chk("rsp_err", g, rsp_err[g], e.err);
                    end
                end
            end
            prev_c[g] = caddr[g];
        end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n, a, c0;
        int ord [7] = '{0, 0, 0, 3, 1, 2, 3};
        for (int g = 0; g < 2; g++) begin
            req_valid[g] = '0;
            req_rd[g] = '0;
            req_lock[g] = '0;
            req_addr[g] = '0;
            req_wdata[g] = '0;
            hold[g] = 1'b0;
            drv_hang[g] = 1'b0;
            drv_lat[g] = 3;
            drv_rdata[g] = '0;
            op_status[g] = 1'b0;
            rd_data[g] = '0;
            prev_c[g] = 12'hC00;
        end
        nxt_v = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_caddr", g, caddr[g], 12'hC00);
            chk("rst_wr_data", g, wr_data[g], 0);
            chk("rst_ack", g, req_ack[g], 0);
            chk("rst_grant", g, req_grant[g], 0);
            chk("rst_rdata", g, rsp_rdata[g], 0);
            chk("rst_err", g, rsp_err[g], 0);
            chk("rst_tflag", g, timeout_flag[g], 0);
            chk("rst_busy", g, busy[g], 0);
        end
        rst_n = 1'b1;

        drv_lat[0] = 5;
        drv_rdata[0] = 16'h0101;
        push(0, 12'h214, 16'hC0A8, 4'b0010, 16'h0101, 1'b0);
        set_req(0, 1, 1'b0, 1'b0, 10'h214, 16'hC0A8);
        @(negedge clk);
        chk("wr_strobe_lat", 0, caddr[0], 12'h214);
        chk("wr_busy", 0, busy[0], 1);
        n = 1;
        while (!req_ack[0][1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wr_ack_lat", 0, n, 6);
        chk("gap_strobe", 0, caddr[0][11], 1);
        drain(0);

        drv_lat[0] = 3;
        drv_rdata[0] = 16'h0022;
        push(0, 12'h608, 16'h0000, 4'b0100, 16'h0022, 1'b0);
        set_req(0, 2, 1'b1, 1'b0, 10'h208, 16'h0000);
        drain(0);

        drv_lat[0] = 2;
        drv_rdata[0] = 16'h00AA;
        push(0, 12'h220, 16'h5555, 4'b0100, 16'h00AA, 1'b0);
        push(0, 12'h222, 16'h5555, 4'b0100, 16'h00AA, 1'b0);
        push(0, 12'h111, 16'h1111, 4'b0010, 16'h00AA, 1'b0);
        nxt_v = 1'b1;
        nxt_r = 2;
        nxt_a = 10'h222;
        nxt_lk = 1'b0;
        set_req(0, 2, 1'b0, 1'b1, 10'h220, 16'h5555);
        repeat (2) @(negedge clk);
        set_req(0, 1, 1'b0, 1'b0, 10'h111, 16'h1111);
        drain(0);

        drv_hang[0] = 1'b1;
        push(0, 12'h3FF, 16'h1234, 4'b1000, 16'h0000, 1'b1);
        set_req(0, 3, 1'b0, 1'b0, 10'h3FF, 16'h1234);
        @(negedge clk);
        n = 1;
        while (!req_ack[0][3] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_ack_lat", 0, n, 17);
        chk("tmo_flag", 0, timeout_flag[0], 1);
        drain(0);
        drv_hang[0] = 1'b0;

        drv_lat[0] = 4;
        drv_rdata[0] = 16'hBEEF;
        push(0, 12'h404, 16'h0000, 4'b0001, 16'hBEEF, 1'b0);
        set_req(0, 0, 1'b1, 1'b0, 10'h004, 16'h0000);
        drain(0);
        chk("tmo_flag_sticky", 0, timeout_flag[0], 1);

        drv_lat[0] = 2;
        drv_rdata[0] = 16'h7777;
        hold[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int r;
            r = (k + 1) % N;
            push(0, 12'h100 + 12'(r), 16'hA000 + 16'(r), 4'(1 << r), 16'h7777, 1'b0);
        end
        for (int r = 0; r < N; r++) set_req(0, r, 1'b0, 1'b0, 10'h100 + 10'(r), 16'hA000 + 16'(r));
        a = 0;
        n = 0;
        while (a < 8 && n < 300) begin
            @(negedge clk);
            n++;
            if (req_ack[0] != 0) a++;
        end
        req_valid[0] = '0;
        hold[0] = 1'b0;
        drain(0);

        drv_lat[1] = 2;
        drv_rdata[1] = 16'h5A5A;
        push(1, 12'h202, 16'hB002, 4'b0100, 16'h5A5A, 1'b0);
        set_req(1, 2, 1'b0, 1'b0, 10'h202, 16'hB002);
        drain(1);
        hold[1] = 1'b1;
        for (int k = 0; k < 7; k++)
            push(1, 12'h200 + 12'(ord[k]), 16'hB000 + 16'(ord[k]), 4'(1 << ord[k]), 16'h5A5A, 1'b0);
        for (int r = 0; r < N; r++) set_req(1, r, 1'b0, 1'b0, 10'h200 + 10'(r), 16'hB000 + 16'(r));
        a = 0;
        c0 = 0;
        n = 0;
        while (a < 7 && n < 300) begin
            @(negedge clk);
            n++;
            if (req_ack[1] != 0) a++;
            if (req_ack[1][0]) c0++;
            if (c0 == 3) req_valid[1][0] = 1'b0;
        end
        req_valid[1] = '0;
        hold[1] = 1'b0;
        drain(1);

        drv_hang[0] = 1'b1;
        push(0, 12'h155, 16'h9999, 4'b0010, 16'h0000, 1'b0);
        set_req(0, 1, 1'b0, 1'b0, 10'h155, 16'h9999);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 0, busy[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_caddr", 0, caddr[0], 12'hC00);
        chk("async_rst_wr_data", 0, wr_data[0], 0);
        chk("async_rst_grant", 0, req_grant[0], 0);
        chk("async_rst_busy", 0, busy[0], 0);
        q0.delete();
        req_valid[0] = '0;
        drv_hang[0] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_ack", 0, req_ack[0], 0);
        end
        chk("rst_tflag_clear", 0, timeout_flag[0], 0);
        rst_n = 1'b1;
        drv_lat[0] = 3;
        drv_rdata[0] = 16'h1357;
        push(0, 12'h4AA, 16'h0000, 4'b1000, 16'h1357, 1'b0);
        set_req(0, 3, 1'b1, 1'b0, 10'h0AA, 16'h0000);
        drain(0);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
